// File: rtl/disp_pkg.sv
// Shared types and constants for the display VRAM read controller:
// resolution table, controller state encoding and burst/frame sizing helpers.
package disp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    ADDR  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  localparam int REM_W = 24;

  function automatic int h_pixels(input logic [1:0] resol);
    case (resol)
      2'd0:    return 640;
      2'd1:    return 800;
      2'd2:    return 1024;
      2'd3:    return 1280;
      default: return 640;
    endcase
  endfunction

  function automatic int v_lines(input logic [1:0] resol);
    case (resol)
      2'd0:    return 480;
      2'd1:    return 600;
      2'd2:    return 768;
      2'd3:    return 1024;
      default: return 480;
    endcase
  endfunction

  function automatic int bytes_per_burst(input int burst_len, input int data_width);
    return burst_len * data_width / 8;
  endfunction

  function automatic logic [REM_W-1:0] total_bursts(input logic [1:0] resol, input int burst_len,
                                                     input int data_width, input int pix_bytes);
    return REM_W'((h_pixels(resol) * v_lines(resol) * pix_bytes) /
                  bytes_per_burst(burst_len, data_width));
  endfunction

endpackage

// File: rtl/disp_burst_tracker.sv
// Counts accepted-but-incomplete read bursts; the count never wraps below zero
// when a stray RLAST arrives, and can_issue limits the number in flight.
module disp_burst_tracker #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic ACLK,
  input  logic ARST,
  input  logic inc,
  input  logic dec,
  output logic can_issue,
  output logic empty
);

  logic [3:0] count_r;

  // in-flight burst counter; simultaneous issue and completion cancel out
  always_ff @(posedge ACLK) begin
    if (ARST) begin
      count_r <= 4'd0;
    end else if (inc && !dec) begin
      count_r <= count_r + 4'd1;
    end else if (!inc && dec && (count_r != 4'd0)) begin
      count_r <= count_r - 4'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign can_issue = (count_r < 4'(MAX_OUTSTANDING));
  assign empty     = (count_r == 4'd0);

endmodule

// File: rtl/disp_vramctrl_mb.sv
// Frame-scan AXI4 read-address controller keeping up to MAX_OUTSTANDING bursts in flight.
// Define DISP_VRAMCTRL_ERRCHK_EN to add the RRESP input and sticky RD_ERR output.
module disp_vramctrl_mb
  import disp_pkg::*;
#(
  parameter int C_DATA_WIDTH    = 64,
  parameter int BURST_LEN       = 16,
  parameter int MAX_OUTSTANDING = 4,
  parameter int PIX_BYTES       = 4
) (
  input  logic        ACLK,
  input  logic        ARST,
  output logic [31:0] ARADDR,
  output logic [7:0]  ARLEN,
  output logic [2:0]  ARSIZE,
  output logic        ARVALID,
  input  logic        ARREADY,
  input  logic        RLAST,
  input  logic        RVALID,
  output logic        RREADY,
  input  logic [1:0]  RESOL,
  input  logic        VRSTART,
  input  logic        DISPON,
  input  logic [28:0] DISPADDR,
  input  logic        BUF_WREADY,
  output logic        FRAME_DONE
`ifdef DISP_VRAMCTRL_ERRCHK_EN
  ,
  input  logic [1:0]  RRESP,
  output logic        RD_ERR
`endif
);

  localparam int          BPB       = bytes_per_burst(BURST_LEN, C_DATA_WIDTH);
  localparam logic [28:0] ADDR_STEP = 29'(BPB);
  localparam logic [28:0] ADDR_MASK = ~(29'(BPB) - 29'd1);

  state_e             state_r, state_s;
  logic               arvalid_r, arvalid_s;
  logic [31:0]        araddr_r, araddr_s;
  logic [28:0]        addr_r, addr_s, base_r, base_s;
  logic [1:0]         resol_r, resol_s;
  logic [REM_W-1:0]   remaining_r, remaining_s;
  logic               abort_r, abort_s, restart_r, restart_s;
  logic               frame_done_r, frame_done_s;
  logic               rready_r;
  logic               ar_hs_s, r_last_s, can_issue_s, empty_s;

  assign ar_hs_s  = arvalid_r & ARREADY;
  assign r_last_s = RVALID & rready_r & RLAST;

  disp_burst_tracker #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_tracker (
    .ACLK      (ACLK),
    .ARST      (ARST),
    .inc       (ar_hs_s),
    .dec       (r_last_s),
    .can_issue (can_issue_s),
    .empty     (empty_s)
  );

  // next-state and next-output decode; overrun and display-off force a drain
  always_comb begin
    state_s      = state_r;
    arvalid_s    = arvalid_r;
    araddr_s     = araddr_r;
    addr_s       = addr_r;
    base_s       = base_r;
    resol_s      = resol_r;
    remaining_s  = remaining_r;
    abort_s      = abort_r;
    restart_s    = restart_r;
    frame_done_s = 1'b0;
    if (state_r == IDLE) begin
      abort_s   = 1'b0;
      restart_s = 1'b0;
    end else if (VRSTART && DISPON) begin
      abort_s   = 1'b1;
      restart_s = 1'b1;
      base_s    = DISPADDR & ADDR_MASK;
      resol_s   = RESOL;
    end else if (!DISPON) begin
      abort_s   = 1'b1;
      restart_s = 1'b0;
    end else begin
      abort_s   = abort_r;
      restart_s = restart_r;
    end
    case (state_r)
      IDLE: begin
        if (VRSTART && DISPON) begin
          base_s      = DISPADDR & ADDR_MASK;
          resol_s     = RESOL;
          addr_s      = DISPADDR & ADDR_MASK;
          remaining_s = total_bursts(RESOL, BURST_LEN, C_DATA_WIDTH, PIX_BYTES);
          state_s     = REQ;
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        if (abort_s || (remaining_r == {REM_W{1'b0}})) begin
          state_s = DRAIN;
        end else if (can_issue_s && BUF_WREADY) begin
          arvalid_s = 1'b1;
          araddr_s  = {3'b000, addr_r};
          state_s   = ADDR;
        end else begin
          state_s = REQ;
        end
      end
      ADDR: begin
        if (ar_hs_s) begin
          arvalid_s   = 1'b0;
          addr_s      = addr_r + ADDR_STEP;
          remaining_s = remaining_r - REM_W'(1);
          if (abort_s || (remaining_s == {REM_W{1'b0}})) begin
            state_s = DRAIN;
          end else begin
            state_s = REQ;
          end
        end else begin
          state_s = ADDR;
        end
      end
      DRAIN: begin
        if (!empty_s) begin
          state_s = DRAIN;
        end else if (restart_s) begin
          addr_s      = base_s;
          remaining_s = total_bursts(resol_s, BURST_LEN, C_DATA_WIDTH, PIX_BYTES);
          abort_s     = 1'b0;
          restart_s   = 1'b0;
          state_s     = REQ;
        end else if (abort_s) begin
          abort_s = 1'b0;
          state_s = IDLE;
        end else begin
          frame_done_s = 1'b1;
          state_s      = IDLE;
        end
      end
      default: begin
        state_s   = IDLE;
        arvalid_s = 1'b0;
      end
    endcase
  end

  // controller state and registered AXI/frame outputs
  always_ff @(posedge ACLK) begin
    if (ARST) begin
      state_r      <= IDLE;
      arvalid_r    <= 1'b0;
      araddr_r     <= 32'd0;
      addr_r       <= 29'd0;
      base_r       <= 29'd0;
      resol_r      <= 2'd0;
      remaining_r  <= {REM_W{1'b0}};
      abort_r      <= 1'b0;
      restart_r    <= 1'b0;
      frame_done_r <= 1'b0;
      rready_r     <= 1'b0;
    end else begin
      state_r      <= state_s;
      arvalid_r    <= arvalid_s;
      araddr_r     <= araddr_s;
      addr_r       <= addr_s;
      base_r       <= base_s;
      resol_r      <= resol_s;
      remaining_r  <= remaining_s;
      abort_r      <= abort_s;
      restart_r    <= restart_s;
      frame_done_r <= frame_done_s;
      rready_r     <= 1'b1;
    end
  end

  assign ARADDR     = araddr_r;
  assign ARVALID    = arvalid_r;
  assign ARLEN      = 8'(BURST_LEN - 1);
  assign ARSIZE     = 3'($clog2(C_DATA_WIDTH / 8));
  assign RREADY     = rready_r;
  assign FRAME_DONE = frame_done_r;

`ifdef DISP_VRAMCTRL_ERRCHK_EN
  logic rd_err_r;

  // sticky error on any non-OKAY beat; a new accepted frame start clears it
  always_ff @(posedge ACLK) begin
    if (ARST) begin
      rd_err_r <= 1'b0;
    end else if (RVALID && rready_r && (RRESP != 2'b00)) begin
      rd_err_r <= 1'b1;
    end else if (VRSTART && DISPON) begin
      rd_err_r <= 1'b0;
    end else begin
      rd_err_r <= rd_err_r;
    end
  end

  assign RD_ERR = rd_err_r;
`else
  // no response checking in this build
`endif

endmodule
